// File: rtl/aes_block_tx_sequencer.sv
// Streams one accepted AES block as NUM_BYTES bytes into the serial byte transmitter.
// Optional trailer byte enabled by defining TX_FRAME_DELIM_EN.
module aes_block_tx_sequencer #(
    parameter int         NUM_BYTES  = 16,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter logic [7:0] DELIM_BYTE = 8'h0A
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [8*NUM_BYTES-1:0]   BlockIn,
    input  logic                     BlockValid,
    output logic                     BlockReady,
    output logic [7:0]               writeByte,
    output logic                     WriteEn,
    output logic                     loadNewByte,
    input  logic                     WriteByteReady,
    output logic                     Busy,
    output logic                     BlockDone
);

    localparam int BLOCK_W = 8 * NUM_BYTES;
    localparam int IDX_W   = $clog2(NUM_BYTES + 1);
`ifdef TX_FRAME_DELIM_EN
    localparam int LAST_INT = NUM_BYTES;
`else
    localparam int LAST_INT = NUM_BYTES - 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_INT);
    localparam logic [IDX_W-1:0] DELIM_IDX = IDX_W'(NUM_BYTES);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [7:0] headByte(input logic [BLOCK_W-1:0] v);
        headByte = MSB_FIRST ? v[BLOCK_W-1 -: 8] : v[7:0];
    endfunction

    function automatic logic [BLOCK_W-1:0] advance(input logic [BLOCK_W-1:0] v);
        advance = MSB_FIRST ? (v << 8) : (v >> 8);
    endfunction

    state_t              state_r, nextState_s;
    logic [BLOCK_W-1:0]  shift_r, shiftNext_s;
    logic [IDX_W-1:0]    idx_r, idxNext_s;
    logic [7:0]          writeByte_r, writeByteNext_s;
    logic                blockReady_r, writeEn_r, loadNewByte_r, busy_r, blockDone_r;
    logic                blockReadyNext_s, writeEnNext_s, loadNewByteNext_s, busyNext_s, blockDoneNext_s;
    logic                lastByte_s;

    assign lastByte_s = (idx_r == LAST_IDX);

    // State, capture/shift register and byte index
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
            shift_r <= {BLOCK_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= nextState_s;
            shift_r <= shiftNext_s;
            idx_r   <= idxNext_s;
        end
    end

    // Next-state and datapath update
    always_comb begin
        nextState_s = state_r;
        shiftNext_s = shift_r;
        idxNext_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (BlockValid) begin
                    nextState_s = LOAD;
                    shiftNext_s = BlockIn;
                    idxNext_s   = {IDX_W{1'b0}};
                end else begin
                    nextState_s = IDLE;
                end
            end
            LOAD: nextState_s = WAIT;
            WAIT: begin
                if (WriteByteReady && lastByte_s) begin
                    nextState_s = DONE;
                end else if (WriteByteReady) begin
                    nextState_s = LOAD;
                    shiftNext_s = advance(shift_r);
                    idxNext_s   = idx_r + IDX_ONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        blockReadyNext_s  = (nextState_s == IDLE);
        writeEnNext_s     = (nextState_s == LOAD) || (nextState_s == WAIT);
        busyNext_s        = writeEnNext_s;
        loadNewByteNext_s = (nextState_s == LOAD);
        blockDoneNext_s   = (nextState_s == DONE);
        writeByteNext_s   = writeByte_r;
        if (nextState_s == LOAD) begin
`ifdef TX_FRAME_DELIM_EN
            if (idxNext_s == DELIM_IDX) begin
                writeByteNext_s = DELIM_BYTE;
            end else begin
                writeByteNext_s = headByte(shiftNext_s);
            end
`else
            writeByteNext_s = headByte(shiftNext_s);
`endif
        end else begin
            writeByteNext_s = writeByte_r;
        end
    end

    // Registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            blockReady_r  <= 1'b1;
            writeEn_r     <= 1'b0;
            busy_r        <= 1'b0;
            loadNewByte_r <= 1'b0;
            blockDone_r   <= 1'b0;
            writeByte_r   <= 8'h00;
        end else begin
            blockReady_r  <= blockReadyNext_s;
            writeEn_r     <= writeEnNext_s;
            busy_r        <= busyNext_s;
            loadNewByte_r <= loadNewByteNext_s;
            blockDone_r   <= blockDoneNext_s;
            writeByte_r   <= writeByteNext_s;
        end
    end

    assign BlockReady  = blockReady_r;
    assign writeByte   = writeByte_r;
    assign WriteEn     = writeEn_r;
    assign loadNewByte = loadNewByte_r;
    assign Busy        = busy_r;
    assign BlockDone   = blockDone_r;

endmodule
